// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bus with start/busy/done handshake for serial_adder
//   start, a, b      : driven by the requester (master)
//   busy, done, sum, cout : driven by the adder (slave)
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-add slice per cycle, LSB first
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_adder_if (start/a/b in, busy/done/sum/cout out)
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, acc_q, acc_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             s, c;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end
    // Full-add slice on the current LSBs of the operand shift registers.
    assign s = sha_q[0] ^ shb_q[0] ^ carry_q;
    assign c = (sha_q[0] & shb_q[0]) | (carry_q & (sha_q[0] ^ shb_q[0]));
    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE, giving back-to-back operation.
                state_d = IDLE;
                if (bus.start) begin
                    sha_d   = bus.a;
                    shb_d   = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                acc_d   = {s, acc_q[WIDTH-1:1]};
                carry_d = c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {s, acc_q[WIDTH-1:1]};
                    cout_d  = c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed self-checking bench for serial_adder (WIDTH 8 and 4)
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();
    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    // Reference model for the 8-bit instance: a request is accepted whenever no add
    // is outstanding; the result appears WIDTH cycles later as plain integer a+b.
    int         left = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_sum = '0;
    logic       m_cout = 1'b0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    bit         seen = 1'b0;
    always @(posedge clk) begin
        seen <= 1'b1;
        if (rst) begin
            left   <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (left > 0) begin
            left   <= left - 1;
            m_done <= (left == 1);
            if (left == 1) {m_cout, m_sum} <= 9'(int'(m_a) + int'(m_b));
        end else begin
            m_done <= 1'b0;
            if (bus8.start) begin
                m_a  <= bus8.a;
                m_b  <= bus8.b;
                left <= 8;
            end
        end
    end
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (seen) begin
            check("busy", 32'(bus8.busy), 32'(left > 0));
            check("done", 32'(bus8.done), 32'(m_done));
            check("sum", 32'(bus8.sum), 32'(m_sum));
            check("cout", 32'(bus8.cout), 32'(m_cout));
        end
    end
    task automatic wait_done(output int n, output int bn);
        n  = 0;
        bn = 0;
        do begin
            @(negedge clk);
            n++;
            bn += int'(bus8.busy);
        end while (!bus8.done && n < 40);
        if (!bus8.done) check("done_timeout", 0, 1);
    endtask
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] es, input logic ec);
        int n, bn;
        bus8.start = 1'b1;
        bus8.a     = x;
        bus8.b     = y;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        wait_done(n, bn);
        check("latency", n, 9);
        check("busy_cycles", bn, 8);
        check("lit_sum", 32'(bus8.sum), 32'(es));
        check("lit_cout", 32'(bus8.cout), 32'(ec));
        check("model_sum", 32'(m_sum), 32'(es));
        check("model_cout", 32'(m_cout), 32'(ec));
        @(posedge clk);
        #1;
    endtask
    initial begin
        int n, bn;
        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(bus8.busy), 0);
        check("rst_done", 32'(bus8.done), 0);
        check("rst_sum", 32'(bus8.sum), 0);
        check("rst_cout", 32'(bus8.cout), 0);
        check("rst_sum4", 32'(bus4.sum), 0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0);
        run_op(8'h0F, 8'h01, 8'h10, 1'b0);
        run_op(8'hA5, 8'h5A, 8'hFF, 1'b0);
        run_op(8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1);
        // Start pulse during RUN is ignored; start held in DONE relaunches immediately.
        bus8.start = 1'b1;
        bus8.a     = 8'h03;
        bus8.b     = 8'h04;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus8.start = 1'b1;
        bus8.a     = 8'h10;
        bus8.b     = 8'h10;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        wait_done(n, bn);
        check("ignored_sum", 32'(bus8.sum), 32'h07);
        bus8.start = 1'b1;
        bus8.a     = 8'h10;
        bus8.b     = 8'h10;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        check("b2b_busy", 32'(bus8.busy), 1);
        wait_done(n, bn);
        check("b2b_latency", n, 9);
        check("b2b_sum", 32'(bus8.sum), 32'h20);
        @(posedge clk);
        #1;
        // Reset in the middle of RUN aborts and clears the result.
        bus8.start = 1'b1;
        bus8.a     = 8'h80;
        bus8.b     = 8'h80;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus8.busy), 0);
        check("abort_sum", 32'(bus8.sum), 0);
        check("abort_cout", 32'(bus8.cout), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_nodone", 32'(bus8.done), 0);
        end
        @(posedge clk);
        #1;
        run_op(8'h01, 8'h02, 8'h03, 1'b0);
        // Random traffic with occasional resets, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            bus8.start = ($urandom_range(0, 3) == 0);
            bus8.a     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            bus8.b     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            rst        = ($urandom_range(0, 599) == 0);
            @(posedge clk);
            #1;
        end
        rst        = 1'b0;
        bus8.start = 1'b0;
        @(posedge clk);
        #1;
        // 4-bit instance: overflow wraps and result is valid 5 cycles after start.
        bus4.start = 1'b1;
        bus4.a     = 4'hF;
        bus4.b     = 4'h1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus4.done && n < 20);
        check("w4_latency", n, 5);
        check("w4_sum", 32'(bus4.sum), 0);
        check("w4_cout", 32'(bus4.cout), 1);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
